// File: rtl/poly1305_stream_mac.sv
// Poly1305 one-time authenticator: key load, block-serial accumulate with a
// limb-serial multiplier, two-step fold modulo 2^130-5, then tag out / verify.
module poly1305_stream_mac #(
  parameter int LIMB_W    = 26,
  parameter bit VERIFY_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [255:0] key,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [127:0] blk_data,
  input  logic [4:0]   blk_bytes,
  input  logic         blk_last,
  input  logic         abort,
  input  logic [127:0] exp_tag,
  output logic         tag_valid,
  input  logic         tag_ready,
  output logic [127:0] tag,
  output logic         tag_ok,
  output logic         len_err
);
  localparam int N_LIMB = (130 + LIMB_W - 1) / LIMB_W;
  localparam int OPW    = N_LIMB * LIMB_W;
  localparam int PPW    = LIMB_W + 128;
  localparam int CW     = (N_LIMB > 1) ? $clog2(N_LIMB) : 1;
  localparam logic [130:0] P     = 131'h3_ffffffff_ffffffff_ffffffff_fffffffb;
  localparam logic [127:0] CLAMP = 128'h0ffffffc0ffffffc0ffffffc0fffffff;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_MUL, S_RED1, S_RED2, S_FINAL, S_OUT
  } state_t;

  state_t        state;
  logic [127:0]  r_q, s_q, exp_q;
  logic [130:0]  acc;
  logic [OPW-1:0] op_q;      // operand bits [129:0], zero padded to whole limbs
  logic [258:0]  prod;
  logic [132:0]  red_q;
  logic [CW-1:0] cnt;
  logic          last_q;

  logic          bad_len;
  logic [4:0]    n_eff;
  logic [128:0]  m;
  logic [130:0]  sum;
  logic [258:0]  prod_init;
  logic [LIMB_W-1:0] limb;
  logic [PPW-1:0] pp;
  logic [258:0]  pp_sh;
  logic [132:0]  red1;
  logic [130:0]  red2;
  logic [130:0]  a1, a2;
  logic [127:0]  tag_next;

  // Block padding: keep n bytes, set the 2^(8n) marker bit; bad counts act as 16.
  always_comb begin
    bad_len = (blk_bytes == 5'd0) || (blk_bytes > 5'd16);
    n_eff   = bad_len ? 5'd16 : blk_bytes;
    m       = '0;
    for (int i = 0; i < 16; i++)
      if (5'(i) < n_eff) m[8*i +: 8] = blk_data[8*i +: 8];
    m[{n_eff, 3'b000}] = 1'b1;
  end

  // Multiplier datapath; operand bit 130 is folded in up front as r<<130
  // so the limbs only need to cover bits [129:0].
  always_comb begin
    sum       = acc + {2'b00, m};
    prod_init = sum[130] ? (259'(r_q) << 130) : '0;
    limb      = op_q[int'(cnt)*LIMB_W +: LIMB_W];
    pp        = PPW'(limb) * PPW'(r_q);
    pp_sh     = 259'(pp) << (int'(cnt) * LIMB_W);
  end

  // Reduction via 2^130 == 5 and final conditional subtracts.
  always_comb begin
    red1     = 133'(prod[129:0]) + 133'(prod[258:130]) * 133'd5;
    red2     = 131'(red_q[129:0]) + 131'(red_q[132:130]) * 131'd5;
    a1       = (acc >= P) ? acc - P : acc;
    a2       = (a1 >= P) ? a1 - P : a1;
    tag_next = 128'(a2 + {3'b000, s_q});
  end

  // Control FSM with registered handshake outputs and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE; r_q <= '0; s_q <= '0; acc <= '0; exp_q <= '0;
      op_q <= '0; prod <= '0; red_q <= '0; cnt <= '0; last_q <= 1'b0;
      key_ready <= 1'b1; blk_ready <= 1'b0; tag_valid <= 1'b0;
      tag <= '0; tag_ok <= 1'b0; len_err <= 1'b0;
    end else if (abort) begin
      state <= S_IDLE; r_q <= '0; s_q <= '0; acc <= '0;
      key_ready <= 1'b1; blk_ready <= 1'b0; tag_valid <= 1'b0; tag_ok <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (key_valid) begin
          r_q <= key[127:0] & CLAMP; s_q <= key[255:128]; acc <= '0;
          len_err <= 1'b0; key_ready <= 1'b0; blk_ready <= 1'b1;
          state <= S_WAIT;
        end
        S_WAIT: if (blk_valid) begin
          op_q <= OPW'(sum[129:0]); prod <= prod_init; cnt <= '0;
          last_q <= blk_last;
          if (blk_last) exp_q <= exp_tag;
          if (bad_len) len_err <= 1'b1;
          blk_ready <= 1'b0; state <= S_MUL;
        end
        S_MUL: begin
          prod <= prod + pp_sh;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(N_LIMB - 1)) state <= S_RED1;
        end
        S_RED1: begin red_q <= red1; state <= S_RED2; end
        S_RED2: begin
          acc <= red2;
          if (last_q) state <= S_FINAL;
          else begin blk_ready <= 1'b1; state <= S_WAIT; end
        end
        S_FINAL: begin
          tag <= tag_next; tag_ok <= VERIFY_EN && (tag_next == exp_q);
          tag_valid <= 1'b1; state <= S_OUT;
        end
        S_OUT: if (tag_ready) begin
          tag_valid <= 1'b0; tag_ok <= 1'b0; key_ready <= 1'b1; state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_poly1305_stream_mac.sv
// Self-checking bench for poly1305_stream_mac against a big-integer Poly1305 model.
module tb_poly1305_stream_mac;
  localparam int LIMB_W = 26;
  localparam int N_LIMB = (130 + LIMB_W - 1) / LIMB_W;
  localparam logic [127:0] CLAMP = 128'h0ffffffc0ffffffc0ffffffc0fffffff;

  logic clk = 1'b0, reset_n = 1'b0;
  logic key_valid = 1'b0, blk_valid = 1'b0, blk_last = 1'b0, abort = 1'b0, tag_ready = 1'b0;
  logic [255:0] key = '0;
  logic [127:0] blk_data = '0, exp_tag = '0;
  logic [4:0] blk_bytes = '0;
  logic key_ready, blk_ready, tag_valid, tag_ok, len_err;
  logic [127:0] tag;

  int checks = 0, passes = 0;
  logic [127:0] q_data[$];
  int q_n[$];

  poly1305_stream_mac #(.LIMB_W(LIMB_W), .VERIFY_EN(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .key_valid(key_valid), .key_ready(key_ready), .key(key),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data), .blk_bytes(blk_bytes),
    .blk_last(blk_last), .abort(abort), .exp_tag(exp_tag), .tag_valid(tag_valid),
    .tag_ready(tag_ready), .tag(tag), .tag_ok(tag_ok), .len_err(len_err));

  always #5 clk = ~clk;

  // Poly1305 straight from its definition: h = ((h + m) * r) mod (2^130-5).
  function automatic logic [127:0] poly_ref(input logic [255:0] k);
    logic [263:0] p, h, r, m;
    int n;
    p = (264'd1 << 130) - 264'd5;
    r = {136'd0, k[127:0] & CLAMP};
    h = '0;
    foreach (q_data[i]) begin
      n = q_n[i];
      if (n < 1 || n > 16) n = 16;
      m = '0;
      for (int b = 0; b < n; b++) m[8*b +: 8] = q_data[i][8*b +: 8];
      m[8*n] = 1'b1;
      h = ((h + m) * r) % p;
    end
    return h[127:0] + k[255:128];
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic send_key(input logic [255:0] k);
    int w = 0;
    @(negedge clk); key = k; key_valid = 1'b1;
    while (key_ready !== 1'b1 && w < 200) begin @(negedge clk); w++; end
    if (w >= 200) begin checks++; $display("FAIL key_timeout key_ready=%b", key_ready); end
    @(negedge clk); key_valid = 1'b0;
  endtask

  // Returns at the falling edge just after the accepting rising edge.
  task automatic send_block(input logic [127:0] d, input int n, input logic last, input logic [127:0] e);
    int w = 0;
    @(negedge clk);
    blk_data = d; blk_bytes = 5'(n); blk_last = last; exp_tag = e; blk_valid = 1'b1;
    while (blk_ready !== 1'b1 && w < 200) begin @(negedge clk); w++; end
    if (w >= 200) begin checks++; $display("FAIL blk_timeout blk_ready=%b", blk_ready); end
    @(negedge clk); blk_valid = 1'b0; blk_last = 1'b0;
  endtask

  // Counts falling edges after the last block until tag_valid, then consumes.
  task automatic wait_tag(output logic [127:0] t, output logic ok, output int lat);
    lat = 0;
    while (tag_valid !== 1'b1 && lat < 500) begin @(negedge clk); lat++; end
    if (lat >= 500) begin checks++; $display("FAIL tag_timeout tag_valid=%b", tag_valid); end
    t = tag; ok = tag_ok;
    tag_ready = 1'b1; @(negedge clk); tag_ready = 1'b0;
  endtask

  task automatic run_msg(input logic [255:0] k, input logic [127:0] e,
                         output logic [127:0] t, output logic ok, output int lat);
    send_key(k);
    foreach (q_data[i]) send_block(q_data[i], q_n[i], i == q_data.size() - 1, e);
    wait_tag(t, ok, lat);
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({key_ready, blk_ready, tag_valid, tag_ok, len_err, tag} !== {5'b10000, 128'd0})
      $display("FAIL reset_outputs got kr=%b br=%b tv=%b ok=%b le=%b tag=%h want 1 0 0 0 0 0",
               key_ready, blk_ready, tag_valid, tag_ok, len_err, tag);
    else passes++;
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_zero_key();
    logic [127:0] t; logic ok; int lat;
    q_data = '{{16{8'hAA}}}; q_n = '{16};
    run_msg('0, '0, t, ok, lat);
    checks++; if (t !== 128'd0) $display("FAIL zero_key_tag got %h want 0", t); else passes++;
    // tag_valid rises at the end of the (1 + N_LIMB + 2 + 1)th cycle counting the accept cycle.
    checks++; if (lat != N_LIMB + 3) $display("FAIL tag_latency got %0d want %0d", lat, N_LIMB + 3); else passes++;
  endtask

  task automatic test_r_one();
    logic [127:0] t; logic ok; int lat;
    q_data = '{128'h01}; q_n = '{1};
    run_msg({128'd0, 128'd1}, '0, t, ok, lat);
    checks++; if (t !== 128'h101) $display("FAIL r1_tag got %h want 101", t); else passes++;
    run_msg({{128{1'b1}}, 128'd1}, '0, t, ok, lat);
    checks++; if (t !== 128'h100) $display("FAIL s_wrap_tag got %h want 100", t); else passes++;
  endtask

  task automatic test_rfc();
    logic [7:0] kb[32] = '{8'h85,8'hd6,8'hbe,8'h78,8'h57,8'h55,8'h6d,8'h33,8'h7f,8'h44,8'h52,8'hfe,
      8'h42,8'hd5,8'h06,8'ha8,8'h01,8'h03,8'h80,8'h8a,8'hfb,8'h0d,8'hb2,8'hfd,8'h4a,8'hbf,8'hf6,
      8'haf,8'h41,8'h49,8'hf5,8'h1b};
    logic [7:0] tb_[16] = '{8'ha8,8'h06,8'h1d,8'hc1,8'h30,8'h51,8'h36,8'hc6,8'hc2,8'h2b,8'h8b,
      8'haf,8'h0c,8'h01,8'h27,8'ha9};
    string msg = "Cryptographic Forum Research Group";
    logic [255:0] k; logic [127:0] rfc_tag, d, t; logic ok; int lat;
    for (int i = 0; i < 32; i++) k[8*i +: 8] = kb[i];
    for (int i = 0; i < 16; i++) rfc_tag[8*i +: 8] = tb_[i];
    q_data.delete(); q_n.delete();
    for (int b = 0; b < 3; b++) begin
      d = '0;
      for (int j = 0; j < 16 && 16*b + j < msg.len(); j++) d[8*j +: 8] = msg[16*b + j];
      q_data.push_back(d); q_n.push_back(b == 2 ? 2 : 16);
    end
    // First pass by hand to measure per-block throughput.
    send_key(k);
    send_block(q_data[0], 16, 1'b0, '0);
    lat = 0;
    while (blk_ready !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
    checks++; if (lat != N_LIMB + 2) $display("FAIL blk_throughput got %0d want %0d", lat, N_LIMB + 2); else passes++;
    send_block(q_data[1], 16, 1'b0, '0);
    send_block(q_data[2], 2, 1'b1, '0);
    wait_tag(t, ok, lat);
    checks++; if (t !== rfc_tag) $display("FAIL rfc_tag got %h want %h", t, rfc_tag); else passes++;
    run_msg(k, rfc_tag, t, ok, lat);
    checks++; if (ok !== 1'b1) $display("FAIL rfc_verify_ok got %b want 1", ok); else passes++;
    run_msg(k, rfc_tag ^ 128'd1, t, ok, lat);
    checks++; if (ok !== 1'b0) $display("FAIL rfc_verify_bad got %b want 0", ok); else passes++;
  endtask

  task automatic test_len_err_abort();
    logic [255:0] k; logic [127:0] d, t, want; logic ok; int lat;
    k = {rnd128(), rnd128()}; d = rnd128();
    q_data = '{d}; q_n = '{0};
    want = poly_ref(k);
    run_msg(k, '0, t, ok, lat);
    checks++; if (t !== want) $display("FAIL len0_tag got %h want %h", t, want); else passes++;
    checks++; if (len_err !== 1'b1) $display("FAIL len_err_set got %b want 1", len_err); else passes++;
    send_key(k);
    checks++; if (len_err !== 1'b0) $display("FAIL len_err_clear got %b want 0", len_err); else passes++;
    send_block(rnd128(), 20, 1'b0, '0);   // oversize count, then abort mid-multiply
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    checks++;
    if ({key_ready, blk_ready, tag_valid, len_err} !== 4'b1001)
      $display("FAIL abort_state got kr=%b br=%b tv=%b le=%b want 1 0 0 1", key_ready, blk_ready, tag_valid, len_err);
    else passes++;
    repeat (N_LIMB + 4) @(negedge clk);
    checks++; if (tag_valid !== 1'b0) $display("FAIL abort_no_tag got %b want 0", tag_valid); else passes++;
    // A fresh message must not see any residue of the aborted one.
    k = {rnd128(), rnd128()};
    q_data = '{rnd128(), rnd128()}; q_n = '{16, 7};
    want = poly_ref(k);
    run_msg(k, '0, t, ok, lat);
    checks++; if (t !== want) $display("FAIL post_abort_tag got %h want %h", t, want); else passes++;
  endtask

  task automatic test_backpressure();
    logic [255:0] k; logic [127:0] want, t0; logic ok0, stable; int w;
    k = {rnd128(), rnd128()};
    q_data = '{rnd128()}; q_n = '{11};
    want = poly_ref(k);
    send_key(k);
    send_block(q_data[0], 11, 1'b1, want);
    w = 0;
    while (tag_valid !== 1'b1 && w < 100) begin @(negedge clk); w++; end
    t0 = tag; ok0 = tag_ok;
    checks++; if (t0 !== want || ok0 !== 1'b1) $display("FAIL bp_tag got %h/%b want %h/1", t0, ok0, want); else passes++;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (tag !== t0 || tag_ok !== ok0 || tag_valid !== 1'b1 || key_ready !== 1'b0) stable = 1'b0;
    end
    checks++; if (stable !== 1'b1) $display("FAIL bp_stable got %b want 1", stable); else passes++;
    tag_ready = 1'b1; @(negedge clk); tag_ready = 1'b0;
    checks++;
    if ({tag_valid, tag_ok, key_ready} !== 3'b001 || tag !== t0)
      $display("FAIL bp_consume got tv=%b ok=%b kr=%b tag=%h want 0 0 1 %h", tag_valid, tag_ok, key_ready, tag, t0);
    else passes++;
  endtask

  task automatic test_reset_mid_mul();
    send_key({rnd128(), rnd128()});
    send_block(rnd128(), 0, 1'b1, '0);   // also raises len_err, which reset must clear
    @(negedge clk);
    reset_n = 1'b0; #1;
    checks++;
    if ({key_ready, blk_ready, tag_valid, tag_ok, len_err, tag} !== {5'b10000, 128'd0})
      $display("FAIL reset_mid_mul got kr=%b br=%b tv=%b ok=%b le=%b tag=%h want 1 0 0 0 0 0",
               key_ready, blk_ready, tag_valid, tag_ok, len_err, tag);
    else passes++;
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_random();
    logic [255:0] k; logic [127:0] want, e, t; logic ok, want_ok; int lat, nb, bad;
    bad = 0;
    for (int m = 0; m < 40; m++) begin
      k = {rnd128(), rnd128()};
      q_data.delete(); q_n.delete();
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        q_data.push_back(rnd128()); q_n.push_back($urandom_range(1, 16));
      end
      want = poly_ref(k);
      e = ($urandom_range(0, 1) == 1) ? want : want ^ (128'd1 << $urandom_range(0, 127));
      want_ok = (e == want);
      run_msg(k, e, t, ok, lat);
      checks++;
      if (t !== want || ok !== want_ok) begin
        bad++;
        $display("FAIL random_msg%0d got %h/%b want %h/%b", m, t, ok, want, want_ok);
      end else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_zero_key();
    test_r_one();
    test_rfc();
    test_len_err_abort();
    test_backpressure();
    test_reset_mid_mul();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
